// File: rtl/riscv_memory_arbiter.sv
// riscv_memory_arbiter: N-channel arbiter onto one main-memory port, with an in-order tag FIFO
// that routes each memory_ready back to its issuer. Optional counters under RISCV_ARBITER_STATS_EN.
module riscv_memory_arbiter #(
    parameter int CHANNELS        = 2,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter int ROUND_ROBIN     = 0
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [CHANNELS*ADDR_WIDTH-1:0] req_address,
    input  logic [CHANNELS-1:0]            req_read,
    input  logic [CHANNELS-1:0]            req_write,
    input  logic [CHANNELS*DATA_WIDTH-1:0] req_data,
    output logic [CHANNELS-1:0]            req_grant,
    output logic [DATA_WIDTH-1:0]          resp_data,
    output logic [CHANNELS-1:0]            resp_ready,
    output logic [ADDR_WIDTH-1:0]          memory_address,
    output logic                           memory_read,
    output logic                           memory_write,
    output logic [DATA_WIDTH-1:0]          memory_out,
    input  logic                           memory_stall,
    input  logic [DATA_WIDTH-1:0]          memory_in,
    input  logic                           memory_ready,
    output logic                           unexpected_ready,
    output logic [CHANNELS*32-1:0]         stat_grants,
    output logic [CHANNELS*32-1:0]         stat_wait
);
    localparam int TAG_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;

    // Handshake: a channel is valid while req_read|req_write is high and must hold its request
    // stable until req_grant[i]; the grant cycle is the transfer. Completions arrive in order.
    logic [CHANNELS-1:0]   req_valid;
    logic [TAG_W-1:0]      last_grant;
    logic [TAG_W-1:0]      sel;
    logic                  sel_found;
    logic                  grant_en;
    logic                  pop;
    logic [TAG_W-1:0]      tag_mem [MAX_OUTSTANDING];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [CNT_W-1:0]      count;
    logic [ADDR_WIDTH-1:0] addr_arr [CHANNELS];
    logic [DATA_WIDTH-1:0] data_arr [CHANNELS];

    assign req_valid = req_read | req_write;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_unpack
        assign addr_arr[g] = req_address[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign data_arr[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    function automatic logic [TAG_W-1:0] chan_at(input int k, input logic [TAG_W-1:0] base);
        int idx;
        if (ROUND_ROBIN != 0) idx = (int'(base) + 1 + k) % CHANNELS;
        else                  idx = k;
        return TAG_W'(idx);
    endfunction

    // Scan from the lowest search position last, so the earliest position in search order wins.
    always_comb begin
        sel       = '0;
        sel_found = 1'b0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            if (req_valid[chan_at(k, last_grant)]) begin
                sel       = chan_at(k, last_grant);
                sel_found = 1'b1;
            end
        end
    end

    assign grant_en = sel_found && !memory_stall && !reset && (count < CNT_W'(MAX_OUTSTANDING));

    always_comb begin
        req_grant      = '0;
        memory_address = '0;
        memory_read    = 1'b0;
        memory_write   = 1'b0;
        memory_out     = '0;
        if (grant_en) begin
            req_grant[sel] = 1'b1;
            memory_address = addr_arr[sel];
            memory_write   = req_write[sel];
            memory_read    = req_read[sel] & ~req_write[sel];
            memory_out     = data_arr[sel];
        end
    end

    assign pop       = memory_ready && (count != '0) && !reset;
    assign resp_data = reset ? '0 : memory_in;

    always_comb begin
        resp_ready = '0;
        if (pop) resp_ready[tag_mem[rd_ptr]] = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (grant_en) tag_mem[wr_ptr] <= sel;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr           <= '0;
            wr_ptr           <= '0;
            count            <= '0;
            last_grant       <= TAG_W'(CHANNELS - 1);
            unexpected_ready <= 1'b0;
        end else begin
            if (grant_en) begin
                wr_ptr     <= wr_ptr + 1'b1;
                last_grant <= sel;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (grant_en && !pop)      count <= count + 1'b1;
            else if (pop && !grant_en) count <= count - 1'b1;
            if (memory_ready && (count == '0)) unexpected_ready <= 1'b1;
        end
    end

`ifdef RISCV_ARBITER_STATS_EN
    for (genvar g = 0; g < CHANNELS; g++) begin : g_stats
        logic [31:0] grant_cnt;
        logic [31:0] wait_cnt;
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                grant_cnt <= '0;
                wait_cnt  <= '0;
            end else begin
                if (req_grant[g] && (grant_cnt != '1)) grant_cnt <= grant_cnt + 32'd1;
                if (req_valid[g] && !req_grant[g] && (wait_cnt != '1)) wait_cnt <= wait_cnt + 32'd1;
            end
        end
        assign stat_grants[g*32 +: 32] = grant_cnt;
        assign stat_wait[g*32 +: 32]   = wait_cnt;
    end
`else
    assign stat_grants = '0;
    assign stat_wait   = '0;
`endif

endmodule

// File: tb/tb_riscv_memory_arbiter.sv
// Bench for riscv_memory_arbiter: a fixed-priority and a round-robin instance (3 channels each),
// combinational vector table plus multi-cycle sequences checked against an in-order response queue.
module tb_riscv_memory_arbiter;
    localparam int CH = 3;
    localparam int AW = 32;
    localparam int DW = 32;

    logic            clock;
    logic            reset;
    logic [CH*AW-1:0] req_address;
    logic [CH*DW-1:0] req_data;
    logic [CH-1:0]   req_read, req_write, req_grant, resp_ready;
    logic [DW-1:0]   resp_data, memory_out, memory_in;
    logic [AW-1:0]   memory_address;
    logic            memory_read, memory_write, memory_stall, memory_ready, unexpected_ready;
    logic [CH*32-1:0] stat_grants, stat_wait;

    logic [CH-1:0]   rr_req_read, rr_req_write, rr_req_grant, rr_resp_ready;
    logic [DW-1:0]   rr_resp_data, rr_memory_out;
    logic [AW-1:0]   rr_memory_address;
    logic            rr_memory_read, rr_memory_write, rr_memory_ready, rr_unexpected_ready;
    logic [CH*32-1:0] rr_stat_grants, rr_stat_wait;

    riscv_memory_arbiter #(.CHANNELS(CH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                           .MAX_OUTSTANDING(4), .ROUND_ROBIN(0)) dut (
        .clock(clock), .reset(reset), .req_address(req_address), .req_read(req_read),
        .req_write(req_write), .req_data(req_data), .req_grant(req_grant),
        .resp_data(resp_data), .resp_ready(resp_ready), .memory_address(memory_address),
        .memory_read(memory_read), .memory_write(memory_write), .memory_out(memory_out),
        .memory_stall(memory_stall), .memory_in(memory_in), .memory_ready(memory_ready),
        .unexpected_ready(unexpected_ready), .stat_grants(stat_grants), .stat_wait(stat_wait)
    );

    riscv_memory_arbiter #(.CHANNELS(CH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                           .MAX_OUTSTANDING(4), .ROUND_ROBIN(1)) dut_rr (
        .clock(clock), .reset(reset), .req_address(req_address), .req_read(rr_req_read),
        .req_write(rr_req_write), .req_data(req_data), .req_grant(rr_req_grant),
        .resp_data(rr_resp_data), .resp_ready(rr_resp_ready), .memory_address(rr_memory_address),
        .memory_read(rr_memory_read), .memory_write(rr_memory_write), .memory_out(rr_memory_out),
        .memory_stall(1'b0), .memory_in(memory_in), .memory_ready(rr_memory_ready),
        .unexpected_ready(rr_unexpected_ready), .stat_grants(rr_stat_grants), .stat_wait(rr_stat_wait)
    );

    // clock / reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_due = -1;
    int due_q[$];
    logic [CH-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock cycle on the fixed instance: plays memory (in-order completions at their due
    // cycle), checks grant and response routing, books the expected grant into the scoreboard.
    task automatic run_cycle(input logic [CH-1:0] exp_grant, input int lat, input string tag);
        logic [CH-1:0] exp_resp;
        int due;
        memory_in = $urandom;
        if (due_q.size() > 0 && due_q[0] <= cyc) begin
            void'(due_q.pop_front());
            memory_ready = 1'b1;
        end else begin
            memory_ready = 1'b0;
        end
        #1;
        check({tag, " grant"}, req_grant, exp_grant);
        exp_resp = '0;
        if (memory_ready) begin
            if (exp_q.size() > 0) exp_resp = exp_q.pop_front();
            check({tag, " resp_data"}, resp_data, memory_in);
        end
        check({tag, " resp_ready"}, resp_ready, exp_resp);
        if (exp_grant != '0) begin
            exp_q.push_back(exp_grant);
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            due_q.push_back(due);
        end
        @(posedge clock);
        @(negedge clock);
        memory_ready = 1'b0;
        cyc++;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40 && due_q.size() > 0; i++) run_cycle('0, 1, tag);
        check({tag, " drained"}, 64'(due_q.size() + exp_q.size()), 64'd0);
    endtask

    typedef struct {
        logic [2:0]  rd;
        logic [2:0]  wr;
        logic        stall;
        logic [2:0]  grant;
        logic        mread;
        logic        mwrite;
        logic [31:0] addr;
        logic [31:0] mout;
    } vec_t;

    vec_t vecs[9];
    int   b_pat[12];
    logic [CH-1:0] rr_order[3];

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        vecs[0] = '{3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 32'h000, 32'h00};
        vecs[1] = '{3'b001, 3'b000, 1'b0, 3'b001, 1'b1, 1'b0, 32'h100, 32'hA0};
        vecs[2] = '{3'b110, 3'b000, 1'b0, 3'b010, 1'b1, 1'b0, 32'h200, 32'hB1};
        vecs[3] = '{3'b100, 3'b000, 1'b0, 3'b100, 1'b1, 1'b0, 32'h300, 32'hC2};
        vecs[4] = '{3'b100, 3'b010, 1'b0, 3'b010, 1'b0, 1'b1, 32'h200, 32'hB1};
        vecs[5] = '{3'b001, 3'b001, 1'b0, 3'b001, 1'b0, 1'b1, 32'h100, 32'hA0};
        vecs[6] = '{3'b111, 3'b000, 1'b1, 3'b000, 1'b0, 1'b0, 32'h000, 32'h00};
        vecs[7] = '{3'b000, 3'b100, 1'b0, 3'b100, 1'b0, 1'b1, 32'h300, 32'hC2};
        vecs[8] = '{3'b011, 3'b100, 1'b0, 3'b001, 1'b1, 1'b0, 32'h100, 32'hA0};
        b_pat = '{1, 1, 1, 1, 0, 0, 0, 1, 1, 1, 1, 0};
        rr_order = '{3'b001, 3'b010, 3'b100};

        req_address  = {32'h300, 32'h200, 32'h100};
        req_data     = {32'hC2, 32'hB1, 32'hA0};
        req_read     = '0;
        req_write    = '0;
        memory_stall = 1'b0;
        memory_ready = 1'b0;
        memory_in    = 32'h5A5A_1234;
        rr_req_read  = '0;
        rr_req_write = '0;
        rr_memory_ready = 1'b0;

        // reset state: outputs gated while reset is high even with a request present
        reset    = 1'b1;
        req_read = 3'b001;
        #1;
        check("rst grant", req_grant, 3'b000);
        check("rst mread", memory_read, 1'b0);
        check("rst resp_data", resp_data, 32'h0);
        @(negedge clock);
        req_read = '0;
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("rst unexpected", unexpected_ready, 1'b0);
        check("rst resp_ready", resp_ready, 3'b000);
        @(negedge clock);

        // combinational vectors; requests dropped before the edge so no tags are pushed
        for (int i = 0; i < 9; i++) begin
            req_read     = vecs[i].rd;
            req_write    = vecs[i].wr;
            memory_stall = vecs[i].stall;
            #1;
            check($sformatf("vec%0d grant", i), req_grant, vecs[i].grant);
            check($sformatf("vec%0d mread", i), memory_read, vecs[i].mread);
            check($sformatf("vec%0d mwrite", i), memory_write, vecs[i].mwrite);
            check($sformatf("vec%0d addr", i), memory_address, vecs[i].addr);
            check($sformatf("vec%0d mout", i), memory_out, vecs[i].mout);
            #1;
            req_read     = '0;
            req_write    = '0;
            memory_stall = 1'b0;
            @(negedge clock);
        end

        // fixed priority: ch0 wins every cycle, responses one cycle later
        req_read = 3'b011;
        for (int k = 0; k < 6; k++) run_cycle(3'b001, 1, "fixed");
        req_read = '0;
        drain("fixed");

        // FIFO full: four grants, then none until a pop frees a slot (no same-cycle bypass)
        req_read = 3'b010;
        for (int k = 0; k < 12; k++) run_cycle(b_pat[k] != 0 ? 3'b010 : 3'b000, 6, $sformatf("full%0d", k));
        req_read = '0;
        drain("full");

        // interleaved issuers with uneven latency
        req_read = 3'b100;
        run_cycle(3'b100, 3, "ilv0");
        req_read = 3'b001;
        run_cycle(3'b001, 5, "ilv1");
        req_read = 3'b100;
        run_cycle(3'b100, 5, "ilv2");
        req_read = '0;
        drain("ilv");

        // stall holds off the grant; it lands the cycle stall drops
        req_read     = 3'b001;
        memory_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("stall mread", memory_read, 1'b0);
            run_cycle(3'b000, 1, "stall");
        end
        memory_stall = 1'b0;
        #1;
        check("unstall addr", memory_address, 32'h100);
        check("unstall mread", memory_read, 1'b1);
        run_cycle(3'b001, 1, "unstall");
        req_read = '0;
        drain("unstall");

        // reset with two tags outstanding, then stale completions
        check("pre unexpected", unexpected_ready, 1'b0);
        req_read = 3'b011;
        run_cycle(3'b001, 20, "pre_rst");
        run_cycle(3'b001, 20, "pre_rst");
        reset = 1'b1;
        #1;
        check("mid rst grant", req_grant, 3'b000);
        check("mid rst mread", memory_read, 1'b0);
        @(posedge clock);
        @(negedge clock);
        reset    = 1'b0;
        req_read = '0;
        exp_q.delete();
        due_q.delete();
        last_due = -1;
        for (int k = 0; k < 2; k++) begin
            memory_ready = 1'b1;
            #1;
            check("stale resp_ready", resp_ready, 3'b000);
            @(posedge clock);
            @(negedge clock);
            memory_ready = 1'b0;
        end
        #1;
        check("stale unexpected", unexpected_ready, 1'b1);
        reset = 1'b1;
        #1;
        reset = 1'b0;
        #1;
        check("cleared unexpected", unexpected_ready, 1'b0);
        @(negedge clock);

        // round robin: 0,1,2,0,1,2 with a completion the cycle after each grant
        rr_req_read = 3'b111;
        for (int k = 0; k < 6; k++) begin
            rr_memory_ready = (k > 0);
            #1;
            check($sformatf("rr%0d grant", k), rr_req_grant, rr_order[k % 3]);
            check($sformatf("rr%0d resp", k), rr_resp_ready, k > 0 ? rr_order[(k + 2) % 3] : 3'b000);
            @(posedge clock);
            @(negedge clock);
        end
        rr_req_read     = '0;
        rr_memory_ready = 1'b1;
        #1;
        check("rr last resp", rr_resp_ready, 3'b100);
        for (int i = 0; i < CH; i++) begin
`ifdef RISCV_ARBITER_STATS_EN
            check($sformatf("stat_grants%0d", i), rr_stat_grants[i*32 +: 32], 64'd2);
            check($sformatf("stat_wait%0d", i), rr_stat_wait[i*32 +: 32], 64'd4);
`else
            check($sformatf("stat_grants%0d", i), rr_stat_grants[i*32 +: 32], 64'd0);
            check($sformatf("stat_wait%0d", i), stat_wait[i*32 +: 32], 64'd0);
`endif
        end
        @(posedge clock);
        @(negedge clock);
        rr_memory_ready = 1'b0;
        #1;
        check("rr unexpected", rr_unexpected_ready, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/riscv_memory_arbiter.md
Name: riscv_memory_arbiter

Overview:
- Parametrised N-channel arbiter between caches (instruction, data, future DMA/debug ports) and the single main-memory port.
- Supports fixed-priority or round-robin selection.
- Supports multiple outstanding requests; an in-order tag FIFO routes each memory_ready back to the channel that issued it.
- Replaces the two-channel, single-outstanding mux inside the bus module.

Parameters:
- CHANNELS, 2, number of requesters (1..8); channel 0 is highest priority in fixed mode.
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width.
- MAX_OUTSTANDING, 4, tag FIFO depth (power of two, 2..16).
- ROUND_ROBIN, 0, 0 = fixed priority, 1 = round-robin.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req_address  in  CHANNELS*ADDR_WIDTH  per-channel address; channel i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_read  in  CHANNELS  per-channel read request.
- req_write  in  CHANNELS  per-channel write request.
- req_data  in  CHANNELS*DATA_WIDTH  per-channel write data.
- req_grant  out  CHANNELS  one-hot; the request is accepted in this cycle.
- resp_data  out  DATA_WIDTH  read data broadcast to all channels (equal to memory_in).
- resp_ready  out  CHANNELS  one-hot completion strobe.
- memory_address  out  ADDR_WIDTH  address of the granted request.
- memory_read  out  1  read strobe.
- memory_write  out  1  write strobe.
- memory_out  out  DATA_WIDTH  write data.
- memory_stall  in  1  memory cannot accept a request this cycle.
- memory_in  in  DATA_WIDTH  read data from memory.
- memory_ready  in  1  oldest outstanding request has completed.
- unexpected_ready  out  1  sticky flag: memory_ready arrived with the FIFO empty.

Behaviour:
- Request handshake:
  - A channel requests when req_read or req_write is high.
  - It holds address, data and strobes stable until req_grant[i] is high; the grant cycle is the transfer cycle.
  - If both strobes are high, the request is treated as a write and the read strobe is ignored.
- Grant conditions:
  - At most one grant per cycle.
  - Grant is allowed only when the request is valid, memory_stall=0, tag FIFO count < MAX_OUTSTANDING, and reset=0.
  - A full FIFO blocks grants even when memory_ready pops an entry in the same cycle; there is no bypass.
- Grant selection:
  - Fixed mode: lowest requesting index wins.
  - Round-robin mode: the search starts at last_grant+1 modulo CHANNELS.
  - last_grant updates only in a cycle with a grant; it resets to CHANNELS-1, so channel 0 wins first.
- Memory outputs:
  - memory_address, memory_read, memory_write and memory_out are combinational from the granted channel (zero latency).
  - With no grant, all of them are 0.
  - req_grant is combinational.
- Tag FIFO:
  - On grant, push the channel id; width is max(1, clog2(CHANNELS)).
  - Both reads and writes push, because memory returns exactly one memory_ready per accepted request, in order.
- Response routing:
  - When memory_ready=1 and the FIFO is non-empty, resp_ready[head]=1 in the same cycle and the head is popped.
  - Push and pop in the same cycle leave the count unchanged.
- Unexpected response:
  - memory_ready=1 with the FIFO empty gives no resp_ready and sets unexpected_ready.
  - unexpected_ready clears only on reset.
- Latency: the earliest response is the cycle after the grant. Memory latency is arbitrary but in order; throughput is one request per cycle.
- Reset (asynchronous):
  - FIFO pointers and count go to 0, last_grant to CHANNELS-1, unexpected_ready to 0.
  - All combinational outputs are 0 while reset is high.
  - Reset mid-operation drops outstanding tags; later stale memory_ready pulses set unexpected_ready.
- Wrap-around: FIFO read and write pointers wrap modulo MAX_OUTSTANDING. The count is clog2(MAX_OUTSTANDING)+1 bits wide.

Optional Feature:
- Macro RISCV_ARBITER_STATS_EN.
- When defined:
  - Output stat_grants (CHANNELS*32): per-channel grant counters.
  - Output stat_wait (CHANNELS*32): per-channel counters of cycles with the request high and no grant.
  - All counters saturate at 0xFFFFFFFF and are cleared by reset.
- When undefined: both ports exist and are driven constant 0, with no counter logic.

Test Plan:
- Fixed priority, CHANNELS=2, both channels request reads continuously, memory_ready one cycle after each grant → channel 0 is granted every cycle and channel 1 never; resp_ready[0] pulses each cycle starting one cycle after the first grant.
- Round-robin, CHANNELS=3, all request continuously → grant order 0,1,2,0,1,2; after 6 grants with stats enabled, stat_grants = 2,2,2.
- MAX_OUTSTANDING=4, memory latency 6 cycles, channel 1 requests continuously → exactly 4 grants, then req_grant stays 0 until the first memory_ready. resp_ready order matches grant order, and resp_data equals memory_in on each pulse.
- Interleaved grants ch2, ch0, ch2 with responses delayed by 3, 5 and 5 cycles → resp_ready pulses ch2, ch0, ch2 in that order, one per memory_ready.
- memory_stall=1 for 3 cycles with ch0 requesting address 0x100 → no grant and memory_read=0 during those cycles; grant occurs in the cycle stall drops, with memory_address=0x100.
- Assert reset with 2 requests outstanding, deassert, then pulse memory_ready twice → no resp_ready pulses and unexpected_ready=1; a new reset clears it to 0.
